button_conditioner: RTL and testbench

- Conditions one raw, bouncy, active-high push-button input into clean single-cycle command pulses.
- Sits directly upstream of the dice roller. ROLL feeds the roller's ROLL input; LONG is available to drive the roller's RST as a soft clear.
- Provides a 2-flop synchroniser, press/release debouncing, long-press detection and optional auto-repeat while the button is held.

---
 rtl/button_conditioner.sv | 147 ++++++++++++++
 tb/tb_button_conditioner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce,
// long-press detection and optional ROLL auto-repeat while held.
module button_conditioner #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned LONG_CYCLES     = 50000,
  parameter int unsigned REPEAT_CYCLES   = 0
) (
  input  logic i_clk,
  input  logic RST,
  input  logic BTN_RAW,
  output logic ROLL,
  output logic LONG,
  output logic PRESSED
);

  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  =
    (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] save_q, save_d;
  logic             from_rep_q, from_rep_d;
  logic             roll_q, roll_d;
  logic             long_q, long_d;
  logic             pressed_q, pressed_d;

  // Next-state and output decode; pulses default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    save_d     = save_q;
    from_rep_d = from_rep_q;
    roll_d     = 1'b0;
    long_d     = 1'b0;
    pressed_d  = pressed_q;

    case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = DB_PRESS;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_PRESS: begin
        if (!s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TC) begin
          state_d   = HELD;
          roll_d    = 1'b1;
          pressed_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // Release is checked first so it beats a coincident LONG terminal count.
        if (!s_q) begin
          state_d    = DB_RELEASE;
          save_d     = cnt_q;
          from_rep_d = 1'b0;
          cnt_d      = CNT_W'(1);
        end else if (cnt_q == LONG_TC) begin
          state_d = REPEAT;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!s_q) begin
          state_d    = DB_RELEASE;
          save_d     = cnt_q;
          from_rep_d = 1'b1;
          cnt_d      = CNT_W'(1);
        end else if (REPEAT_CYCLES != 0) begin
          if (cnt_q == REP_TC) begin
            roll_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DB_RELEASE: begin
        // A short release glitch resumes the hold with its count intact.
        if (s_q) begin
          state_d = from_rep_q ? REPEAT : HELD;
          cnt_d   = save_q;
        end else if (cnt_q == DB_TC) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (RST) begin
      s1_q       <= 1'b0;
      s_q        <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      save_q     <= '0;
      from_rep_q <= 1'b0;
      roll_q     <= 1'b0;
      long_q     <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      s1_q       <= BTN_RAW;
      s_q        <= s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      save_q     <= save_d;
      from_rep_q <= from_rep_d;
      roll_q     <= roll_d;
      long_q     <= long_d;
      pressed_q  <= pressed_d;
    end
  end

  assign ROLL    = roll_q;
  assign LONG    = long_q;
  assign PRESSED = pressed_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two parameterisations share one button; a
// run-length reference model feeds a scoreboard checked once per cycle.
module tb_button_conditioner;

  localparam int unsigned D0 = 4, L0 = 20, R0 = 5;
  localparam int unsigned D1 = 2, L1 = 5,  R1 = 0;

  logic i_clk;
  logic RST;
  logic BTN_RAW;
  logic roll0, long0, pressed0;
  logic roll1, long1, pressed1;

  button_conditioner #(.CNT_W(16), .DEBOUNCE_CYCLES(D0), .LONG_CYCLES(L0), .REPEAT_CYCLES(R0)) u0 (
    .i_clk(i_clk), .RST(RST), .BTN_RAW(BTN_RAW),
    .ROLL(roll0), .LONG(long0), .PRESSED(pressed0)
  );

  button_conditioner #(.CNT_W(8), .DEBOUNCE_CYCLES(D1), .LONG_CYCLES(L1), .REPEAT_CYCLES(R1)) u1 (
    .i_clk(i_clk), .RST(RST), .BTN_RAW(BTN_RAW),
    .ROLL(roll1), .LONG(long1), .PRESSED(pressed1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int roll_cnt0 = 0;
  int long_cnt0 = 0;
  logic [5:0] sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: the button is described by runs of equal synchronised
  // samples; a press/release is accepted after DEBOUNCE+1 equal samples, and
  // hold time advances only on edges where s was high on this and the last edge.
  bit m_sy1[2], m_sy[2], m_slast[2], m_pressed[2], m_long_done[2];
  int m_hi[2], m_lo[2], m_age[2], m_rep[2];

  function automatic int prm_d(input int i); return (i == 0) ? int'(D0) : int'(D1); endfunction
  function automatic int prm_l(input int i); return (i == 0) ? int'(L0) : int'(L1); endfunction
  function automatic int prm_r(input int i); return (i == 0) ? int'(R0) : int'(R1); endfunction

  task automatic model_step(input int i, input logic rst, input logic raw, output logic [2:0] e);
    bit s, roll, lng;
    roll = 0;
    lng  = 0;
    if (rst) begin
      m_sy1[i] = 0; m_sy[i] = 0; m_slast[i] = 0; m_pressed[i] = 0;
      m_long_done[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_age[i] = 0; m_rep[i] = 0;
    end else begin
      s = m_sy[i];
      m_sy[i]  = m_sy1[i];
      m_sy1[i] = raw;
      if (s) begin m_hi[i]++; m_lo[i] = 0; end
      else   begin m_lo[i]++; m_hi[i] = 0; end
      if (!m_pressed[i]) begin
        if (m_hi[i] == prm_d(i) + 1) begin
          m_pressed[i] = 1; roll = 1; m_age[i] = 0; m_long_done[i] = 0;
        end
      end else if (m_lo[i] == prm_d(i) + 1) begin
        m_pressed[i] = 0;
      end else if (s && m_slast[i]) begin
        if (!m_long_done[i]) begin
          if (m_age[i] == prm_l(i) - 1) begin
            lng = 1; m_long_done[i] = 1; m_rep[i] = 0;
          end else m_age[i]++;
        end else if (prm_r(i) != 0) begin
          if (m_rep[i] == prm_r(i) - 1) begin roll = 1; m_rep[i] = 0; end
          else m_rep[i]++;
        end
      end
      m_slast[i] = s;
    end
    e = {roll, lng, m_pressed[i]};
  endtask

  // One clock of stimulus: drive, predict the post-edge outputs, enqueue.
  task automatic cycle(input logic rst, input logic raw);
    logic [2:0] e0, e1;
    RST     = rst;
    BTN_RAW = raw;
    model_step(0, rst, raw, e0);
    model_step(1, rst, raw, e1);
    sb.push_back({e1, e0});
    @(negedge i_clk);
  endtask

  task automatic hold(input logic raw, input int n);
    repeat (n) cycle(1'b0, raw);
  endtask

  // Monitor: every cycle the DUTs present outputs, pop and compare.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("u0 cyc%0d {roll,long,pressed}", cyc), int'({roll0, long0, pressed0}), int'(e[2:0]));
        check($sformatf("u1 cyc%0d {roll,long,pressed}", cyc), int'({roll1, long1, pressed1}), int'(e[5:3]));
        if (roll0) roll_cnt0++;
        if (long0) long_cnt0++;
        cyc++;
      end
    end
  end

  initial begin
    int r0, l0, len;
    logic lvl;
    RST = 1'b1;
    BTN_RAW = 1'b0;

    // Reset with button held, then fresh debounce after release of reset.
    r0 = roll_cnt0; l0 = long_cnt0;
    repeat (3) cycle(1'b1, 1'b1);
    hold(1'b1, 20);
    hold(1'b0, 15);
    check("reset_hold rolls", roll_cnt0 - r0, 1);
    check("reset_hold longs", long_cnt0 - l0, 0);

    // Bounce rejection.
    r0 = roll_cnt0; l0 = long_cnt0;
    cycle(1'b0, 1'b1); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
    hold(1'b0, 20);
    check("bounce rolls", roll_cnt0 - r0, 0);
    check("bounce longs", long_cnt0 - l0, 0);

    // Clean press shorter than the long threshold.
    r0 = roll_cnt0; l0 = long_cnt0;
    hold(1'b1, 24);
    hold(1'b0, 15);
    check("clean rolls", roll_cnt0 - r0, 1);
    check("clean longs", long_cnt0 - l0, 0);

    // Long press with repeat: ROLL at 6, LONG at 26, repeats 31..61.
    r0 = roll_cnt0; l0 = long_cnt0;
    hold(1'b1, 60);
    hold(1'b0, 15);
    check("long rolls", roll_cnt0 - r0, 8);
    check("long longs", long_cnt0 - l0, 1);

    // Release glitch while held.
    r0 = roll_cnt0; l0 = long_cnt0;
    hold(1'b1, 12);
    hold(1'b0, 2);
    hold(1'b1, 30);
    hold(1'b0, 15);
    check("glitch rolls", roll_cnt0 - r0, 4);
    check("glitch longs", long_cnt0 - l0, 1);

    // Reset mid-hold: press restarts from scratch.
    r0 = roll_cnt0; l0 = long_cnt0;
    hold(1'b1, 15);
    cycle(1'b1, 1'b1);
    hold(1'b1, 30);
    hold(1'b0, 15);
    check("midrst rolls", roll_cnt0 - r0, 3);
    check("midrst longs", long_cnt0 - l0, 1);

    // Randomised runs of bouncy and long presses with rare resets.
    for (int seg = 0; seg < 160; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(25, 50)) : int'($urandom_range(1, 9));
      for (int k = 0; k < len; k++) cycle(1'($urandom_range(0, 199) == 0), lvl);
    end
    hold(1'b0, 10);

    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
